// File: rtl/dqn_seq_pkg.sv
// Shared phase/step codes and FSM state type for the DQN training sequencer.
// Imported by seq_dwell_timer and dqn_train_sequencer.
package dqn_seq_pkg;

    localparam int STEP_W = 4;
    localparam int CTRL_W = 4;

    localparam logic [CTRL_W-1:0] PH_IDLE     = 4'd0;
    localparam logic [CTRL_W-1:0] PH_FWD_ST   = 4'd1;
    localparam logic [CTRL_W-1:0] PH_WAIT_ENV = 4'd2;
    localparam logic [CTRL_W-1:0] PH_FWD_ST1  = 4'd3;
    localparam logic [CTRL_W-1:0] PH_BWD      = 4'd4;
    localparam logic [CTRL_W-1:0] PH_UPD      = 4'd5;

    localparam logic [STEP_W-1:0] STEP_IDLE      = 4'd0;
    localparam logic [STEP_W-1:0] STEP_FWD_FIRST = 4'd1;
    localparam logic [STEP_W-1:0] STEP_FWD_LAST  = 4'd5;
    localparam logic [STEP_W-1:0] STEP_BWD_FIRST = 4'd6;
    localparam logic [STEP_W-1:0] STEP_BWD_LAST  = 4'd9;
    localparam logic [STEP_W-1:0] STEP_UPD       = 4'd10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FWD_ST,
        S_WAIT_ENV,
        S_FWD_ST1,
        S_BWD,
        S_UPD,
        S_DONE
    } state_t;

    // DONE reports phase 0 even though it is a distinct state.
    function automatic logic [CTRL_W-1:0] ph_of(input state_t s);
        logic [CTRL_W-1:0] ph;
        ph = PH_IDLE;
        case (s)
            S_FWD_ST:   ph = PH_FWD_ST;
            S_WAIT_ENV: ph = PH_WAIT_ENV;
            S_FWD_ST1:  ph = PH_FWD_ST1;
            S_BWD:      ph = PH_BWD;
            S_UPD:      ph = PH_UPD;
            default:    ph = PH_IDLE;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/seq_dwell_timer.sv
// 4-bit dwell counter: flags the last cycle a step code is held.
// Cleared whenever the sequencer is not stepping.
module seq_dwell_timer
    import dqn_seq_pkg::*;
#(
    parameter int STAGE_CYC = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic last_cyc
);

    localparam logic [3:0] LAST = 4'(STAGE_CYC - 1);

    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= 4'd0;
        end else if (en) begin
            cnt <= last_cyc ? 4'd0 : cnt + 4'd1;
        end
    end

    assign last_cyc = (cnt == LAST);

endmodule

// File: rtl/dqn_train_sequencer.sv
// DQN training-iteration sequencer: fwd(st) -> wait env -> fwd(st1) -> bwd -> update.
// Define SEQ_PERF_CNT_EN to add the perf_cyc busy-cycle counter port.
module dqn_train_sequencer
    import dqn_seq_pkg::*;
#(
    parameter int STAGE_CYC = 1,
    parameter int ITER_MAX  = 100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              env_valid,
    output logic [STEP_W-1:0] step,
    output logic [CTRL_W-1:0] controller,
    output logic              sel_st1,
    output logic              act_cap,
    output logic              w_upd_en,
    output logic              busy,
    output logic              done,
    output logic [15:0]       iter_cnt,
    output logic              last_iter
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [15:0]       perf_cyc
`endif
);

    localparam logic [15:0] IMAX = 16'(ITER_MAX);

    state_t            state;
    state_t            state_d;
    logic [STEP_W-1:0] step_d;
    logic              en;
    logic              last;
    logic              env_flag;
    logic              wait_exit;

    assign en = (state == S_FWD_ST) || (state == S_FWD_ST1) ||
                (state == S_BWD) || (state == S_UPD);
    assign wait_exit = env_flag || env_valid;

    seq_dwell_timer #(
        .STAGE_CYC(STAGE_CYC)
    ) u_dwell (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .clr     (!en || abort),
        .last_cyc(last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        step_d  = step;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FWD_ST;
                    step_d  = STEP_FWD_FIRST;
                end
            end
            S_FWD_ST: begin
                if (last) begin
                    if (step == STEP_FWD_LAST) state_d = S_WAIT_ENV;
                    else step_d = step + 4'd1;
                end
            end
            S_WAIT_ENV: begin
                if (wait_exit) begin
                    state_d = S_FWD_ST1;
                    step_d  = STEP_FWD_FIRST;
                end
            end
            S_FWD_ST1: begin
                if (last) begin
                    if (step == STEP_FWD_LAST) begin
                        state_d = S_BWD;
                        step_d  = STEP_BWD_FIRST;
                    end else begin
                        step_d = step + 4'd1;
                    end
                end
            end
            S_BWD: begin
                if (last) begin
                    if (step == STEP_BWD_LAST) begin
                        state_d = S_UPD;
                        step_d  = STEP_UPD;
                    end else begin
                        step_d = step + 4'd1;
                    end
                end
            end
            S_UPD: begin
                if (last) begin
                    state_d = S_DONE;
                    step_d  = STEP_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                step_d  = STEP_IDLE;
            end
        endcase
        if (abort) begin
            state_d = S_IDLE;
            step_d  = STEP_IDLE;
        end
    end

    // Phase-level outputs are registered from the next state so they align with step.
    always_ff @(posedge clk) begin
        if (rst) begin
            step       <= STEP_IDLE;
            controller <= PH_IDLE;
            sel_st1    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            step       <= step_d;
            controller <= ph_of(state_d);
            sel_st1    <= (state_d == S_FWD_ST1) || (state_d == S_BWD);
            busy       <= (state_d != S_IDLE) && (state_d != S_DONE);
            done       <= (state_d == S_DONE);
        end
    end

    assign act_cap  = (state == S_FWD_ST) && (step == STEP_FWD_LAST) && last;
    assign w_upd_en = (state == S_UPD) && last && !abort;

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            env_flag <= 1'b0;
        end else if ((state == S_WAIT_ENV) && wait_exit) begin
            env_flag <= 1'b0;
        end else if (busy && env_valid) begin
            env_flag <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            iter_cnt <= 16'd0;
        end else if ((state == S_DONE) && (iter_cnt != IMAX)) begin
            iter_cnt <= iter_cnt + 16'd1;
        end
    end

    assign last_iter = (iter_cnt == IMAX);

`ifdef SEQ_PERF_CNT_EN
    logic [15:0] run_cyc;

    always_ff @(posedge clk) begin
        if (rst) begin
            run_cyc  <= 16'd0;
            perf_cyc <= 16'd0;
        end else begin
            if (state == S_IDLE) begin
                run_cyc <= 16'd0;
            end else if (busy && (run_cyc != 16'hFFFF)) begin
                run_cyc <= run_cyc + 16'd1;
            end
            if (state == S_DONE) begin
                perf_cyc <= run_cyc;
            end
        end
    end
`endif

endmodule
